// File: rtl/decode_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | decode_sequencer: arms the BEP frame decoder, buffers completed frames     |
// | behind a valid/ready handshake, aborts stalled frames, keeps statistics.   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module decode_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RESTART_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        serial_clock,
  input  logic        dec_full,
  input  logic [95:0] dec_frame,
  output logic        dec_reset_n,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [95:0] frame_data,
  output logic [7:0]  frame_count,
  output logic [7:0]  drop_count,
  output logic [7:0]  timeout_count,
  output logic        busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int RST_W  = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESTART_CYCLES - 1);

  typedef enum logic [0:0] {
    RESTART = 1'b0,
    ARMED   = 1'b1
  } state_t;

  state_t            state;
  logic [RST_W-1:0]  restart_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic handoff;
  logic capture;
  logic load;
  logic timeout;

  // busy doubles as the activity flag: set by the first strobe of a frame.
  assign handoff = frame_valid & frame_ready;
  assign capture = (state == ARMED) & dec_full;
  assign load    = capture & (~frame_valid | frame_ready);
  assign timeout = (state == ARMED) & busy & ~dec_full & ~serial_clock &
                   (idle_cnt == IDLE_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= RESTART;
      restart_cnt   <= '0;
      idle_cnt      <= '0;
      busy          <= 1'b0;
      dec_reset_n   <= 1'b0;
      frame_valid   <= 1'b0;
      frame_data    <= '0;
      frame_count   <= 8'd0;
      drop_count    <= 8'd0;
      timeout_count <= 8'd0;
    end else begin
      if (handoff) begin
        frame_valid <= 1'b0;
        if (frame_count != 8'hFF) frame_count <= frame_count + 8'd1;
      end
      // A capture on the hand-off cycle refills the buffer, keeping valid high.
      if (load) begin
        frame_valid <= 1'b1;
        frame_data  <= dec_frame;
      end
      if (capture && !load && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

      case (state)
        RESTART: begin
          busy     <= 1'b0;
          idle_cnt <= '0;
          if (restart_cnt == RST_LAST) begin
            state       <= ARMED;
            dec_reset_n <= 1'b1;
            restart_cnt <= '0;
          end else begin
            restart_cnt <= restart_cnt + 1'b1;
          end
        end
        ARMED: begin
          if (capture || timeout) begin
            state       <= RESTART;
            dec_reset_n <= 1'b0;
            restart_cnt <= '0;
            busy        <= 1'b0;
            idle_cnt    <= '0;
            if (timeout && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end else if (serial_clock) begin
            busy     <= 1'b1;
            idle_cnt <= '0;
          end else if (busy) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state       <= RESTART;
          dec_reset_n <= 1'b0;
          restart_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | tb_decode_sequencer: directed self-checking bench for decode_sequencer.    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_decode_sequencer;

  localparam int T_CYC = 16;
  localparam int R_CYC = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        serial_clock = 1'b0;
  logic        dec_full = 1'b0;
  logic [95:0] dec_frame = '0;
  logic        dec_reset_n;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [95:0] frame_data;
  logic [7:0]  frame_count;
  logic [7:0]  drop_count;
  logic [7:0]  timeout_count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  localparam logic [95:0] F_SINGLE = 96'hDEADBEEF_00C8_00D2_01_AABBCC;
  localparam logic [95:0] F_A      = 96'h11111111_0101_0202_03_A1A2A3;
  localparam logic [95:0] F_B      = 96'h22222222_0404_0505_06_B1B2B3;
  localparam logic [95:0] F_C      = 96'h33333333_0707_0808_09_C1C2C3;

  decode_sequencer #(.TIMEOUT_CYCLES(T_CYC), .RESTART_CYCLES(R_CYC)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .serial_clock  (serial_clock),
    .dec_full      (dec_full),
    .dec_frame     (dec_frame),
    .dec_reset_n   (dec_reset_n),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_data    (frame_data),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .timeout_count (timeout_count),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_armed();
    for (int i = 0; i < 10 && dec_reset_n !== 1'b1; i++) tick();
    tests++;
    if (dec_reset_n !== 1'b1) begin
      fails++;
      $display("FAIL wait_armed: dec_reset_n=%b required 1 within 10 cycles", dec_reset_n);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; serial_clock = 1'b0; dec_full = 1'b0; frame_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    wait_armed();
  endtask

  task automatic capture(input logic [95:0] f);
    dec_frame = f; dec_full = 1'b1;
    tick();
    dec_full = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; serial_clock = 1'b0; dec_full = 1'b0; frame_ready = 1'b0;
    repeat (3) tick();
    tests++;
    if ({dec_reset_n, frame_valid, busy, frame_count, drop_count, timeout_count} !== 27'd0 ||
        frame_data !== 96'd0) begin
      fails++;
      $display("FAIL reset_outputs: dr=%b v=%b busy=%b fc=%0d dc=%0d tc=%0d data=%h required all 0",
               dec_reset_n, frame_valid, busy, frame_count, drop_count, timeout_count, frame_data);
    end
    reset_n = 1'b1;
    tick();
    tests++;
    if (dec_reset_n !== 1'b0) begin
      fails++; $display("FAIL reset_release_1: dec_reset_n=%b required 0", dec_reset_n);
    end
    tick();
    tests++;
    if (dec_reset_n !== 1'b1) begin
      fails++; $display("FAIL reset_release_2: dec_reset_n=%b required 1", dec_reset_n);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    frame_ready = 1'b1;
    capture(F_SINGLE);
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== F_SINGLE || frame_count !== 8'd0 || dec_reset_n !== 1'b0) begin
      fails++;
      $display("FAIL single_capture: v=%b data=%h fc=%0d dr=%b required v=1 data=%h fc=0 dr=0",
               frame_valid, frame_data, frame_count, dec_reset_n, F_SINGLE);
    end
    tick();
    tests++;
    if (frame_valid !== 1'b0 || frame_count !== 8'd1 || dec_reset_n !== 1'b0) begin
      fails++;
      $display("FAIL single_handoff: v=%b fc=%0d dr=%b required v=0 fc=1 dr=0",
               frame_valid, frame_count, dec_reset_n);
    end
    tick();
    tests++;
    if (dec_reset_n !== 1'b1) begin
      fails++; $display("FAIL single_rearm: dec_reset_n=%b required 1", dec_reset_n);
    end
    frame_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    capture(F_A);
    wait_armed();
    capture(F_B);
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== F_A || drop_count !== 8'd1) begin
      fails++;
      $display("FAIL bp_drop: v=%b data=%h dc=%0d required v=1 data=%h dc=1",
               frame_valid, frame_data, drop_count, F_A);
    end
    wait_armed();
    repeat (3) tick();
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== F_A) begin
      fails++;
      $display("FAIL bp_hold: v=%b data=%h required v=1 data=%h", frame_valid, frame_data, F_A);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    tests++;
    if (frame_valid !== 1'b0 || frame_count !== 8'd1 || drop_count !== 8'd1) begin
      fails++;
      $display("FAIL bp_deliver: v=%b fc=%0d dc=%0d required v=0 fc=1 dc=1",
               frame_valid, frame_count, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    capture(F_A);
    wait_armed();
    frame_ready = 1'b1;
    capture(F_B);
    tests++;
    if (frame_count !== 8'd1 || frame_valid !== 1'b1 || frame_data !== F_B || drop_count !== 8'd0) begin
      fails++;
      $display("FAIL b2b_swap: fc=%0d v=%b data=%h dc=%0d required fc=1 v=1 data=%h dc=0",
               frame_count, frame_valid, frame_data, drop_count, F_B);
    end
    tick();
    frame_ready = 1'b0;
    tests++;
    if (frame_count !== 8'd2 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: fc=%0d v=%b required fc=2 v=0", frame_count, frame_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL to_busy_idle: busy=%b required 0", busy);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin serial_clock = 1'b0; tick(); end
      serial_clock = 1'b1;
      tick();
    end
    serial_clock = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL to_busy_set: busy=%b required 1", busy);
    end
    repeat (T_CYC - 1) tick();
    tests++;
    if (dec_reset_n !== 1'b1 || timeout_count !== 8'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL to_early: dr=%b tc=%0d busy=%b required dr=1 tc=0 busy=1",
               dec_reset_n, timeout_count, busy);
    end
    tick();
    tests++;
    if (dec_reset_n !== 1'b0 || timeout_count !== 8'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_fire: dr=%b tc=%0d busy=%b required dr=0 tc=1 busy=0",
               dec_reset_n, timeout_count, busy);
    end
    do_reset();
    repeat (100) tick();
    tests++;
    if (dec_reset_n !== 1'b1 || timeout_count !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_idle_line: dr=%b tc=%0d busy=%b required dr=1 tc=0 busy=0",
               dec_reset_n, timeout_count, busy);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    capture(F_A);
    wait_armed();
    for (int i = 0; i < 300; i++) begin
      capture(F_B);
      wait_armed();
    end
    tests++;
    if (drop_count !== 8'd255 || frame_data !== F_A || frame_count !== 8'd0) begin
      fails++;
      $display("FAIL sat_drop: dc=%0d data=%h fc=%0d required dc=255 data=%h fc=0",
               drop_count, frame_data, frame_count, F_A);
    end
  endtask

  task automatic test_priority();
    do_reset();
    serial_clock = 1'b1;
    tick();
    serial_clock = 1'b0;
    repeat (T_CYC - 1) tick();
    serial_clock = 1'b1;
    capture(F_C);
    serial_clock = 1'b0;
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== F_C || timeout_count !== 8'd0 ||
        dec_reset_n !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL prio_capture: v=%b data=%h tc=%0d dr=%b busy=%b required v=1 data=%h tc=0 dr=0 busy=0",
               frame_valid, frame_data, timeout_count, dec_reset_n, busy, F_C);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_sequencer.md
# decode_sequencer

Control block for the BEP serial frame decoder: arms the decoder, captures each completed 96-bit data frame into a one-entry output buffer with a valid/ready handshake, and re-arms the decoder through its reset. It aborts and restarts partially received frames after a serial-clock idle timeout. It keeps saturating statistics for delivered, dropped and timed-out frames. It sits between the decoder and the downstream display/UART consumer.

## Interface
- TIMEOUT_CYCLES, 1000000: idle system-clock cycles after the last serial_clock strobe before a partial frame is aborted (≥2).
- RESTART_CYCLES, 2: cycles dec_reset_n is held low per re-arm (≥1).
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- serial_clock  in  1  serial bit strobe, the same signal the decoder samples; used only for activity detection.
- dec_full  in  1  decoder frame-complete flag.
- dec_frame  in  96  {thermostat_id[31:0], room_temp[15:0], set_temp[15:0], state[7:0], tail_1, tail_2, tail_3}.
- dec_reset_n  out  1  registered, synchronous, active-low reset driven to the decoder.
- frame_valid  out  1  output buffer holds an undelivered frame.
- frame_ready  in  1  consumer accepts frame_data this cycle.
- frame_data  out  96  buffered frame; stable while frame_valid=1.
- frame_count  out  8  frames accepted by the consumer; saturates at 255.
- drop_count  out  8  frames lost to a full buffer; saturates at 255.
- timeout_count  out  8  partial frames aborted by timeout; saturates at 255.
- busy  out  1  1 in ARMED after the first serial_clock strobe of a frame.

## Operation
- States: RESTART, ARMED.
- RESTART:
  - dec_reset_n=0.
  - The restart counter counts RESTART_CYCLES cycles, then the block moves to ARMED.
  - idle_cnt and the activity flag are cleared.
- ARMED:
  - dec_reset_n=1.
  - A serial_clock=1 sample sets the activity flag and clears idle_cnt.
  - Otherwise, if the activity flag is set, idle_cnt increments.
  - busy equals the activity flag.
- Capture: in ARMED with dec_full=1, the block decides on the buffer:
  - Buffer free, or being handed off (frame_valid & frame_ready) this cycle: load frame_data from dec_frame and set frame_valid=1.
  - Otherwise: keep the old frame and increment drop_count.
  - In both cases, enter RESTART.
- Timeout: in ARMED with the activity flag set, dec_full=0, serial_clock=0 and idle_cnt=TIMEOUT_CYCLES-1:
  - Enter RESTART and increment timeout_count.
  - No timeout is possible before the first strobe; an idle line is not an error.
- dec_full has priority over timeout and over a simultaneous serial_clock strobe.
- dec_full and serial_clock are ignored in RESTART.
- Handshake:
  - frame_valid & frame_ready at an edge increments frame_count.
  - frame_valid clears at that edge unless a capture loads new data in the same cycle, in which case frame_valid stays 1.
  - frame_data and frame_valid never change while frame_valid=1 and frame_ready=0, except at reset.
- All counters saturate at 255 and do not wrap.

## Timing
- Reset (reset_n=0 at an edge) sets:
  - state=RESTART with the restart counter reloaded, dec_reset_n=0.
  - frame_valid=0, frame_data=0, busy=0.
  - All counts=0, idle_cnt=0.
- Reset mid-frame or mid-handshake discards the buffered frame without counting it.
- After reset deasserts, dec_reset_n stays 0 for RESTART_CYCLES edges, then goes 1. ARMED is entered at the same edge.
- Capture latency: dec_full sampled 1 at edge N gives frame_valid=1 and new frame_data after N, and dec_reset_n=0 after N.
- The decoder clears at edges N+1…N+RESTART_CYCLES.
- ARMED is re-entered after edge N+RESTART_CYCLES.
- Consumer latency: frame_ready sampled at edge M gives frame_valid=0 after M (absent a simultaneous capture), with frame_count updated at M.
- Timeout: last strobe at edge S gives RESTART after edge S+TIMEOUT_CYCLES and timeout_count updated at that same edge.
- All outputs are registered; there is no combinational path from frame_ready or dec_full to any output.

## Test plan
- Reset release:
  - Stimulus: reset_n low 3 cycles, then high, with RESTART_CYCLES=2.
  - Required: dec_reset_n=0 for exactly 2 cycles after release, then 1; all outputs 0.
- Single frame:
  - Stimulus: dec_full=1 with dec_frame=96'hDEADBEEF_00C8_00D2_01_AABBCC; frame_ready held 1.
  - Required: frame_valid one cycle after dec_full with that exact data; frame_count 0→1; dec_reset_n low 2 cycles.
- Backpressure drop:
  - Stimulus: frame_ready=0; two captures, data A then B.
  - Required: frame_data stays A; drop_count=1.
  - Stimulus: then raise frame_ready.
  - Required: A delivered; frame_count=1.
- Simultaneous handoff and capture:
  - Stimulus: frame_valid=1 (data A), frame_ready=1 and dec_full=1 (data B) in the same cycle.
  - Required: frame_count=1; frame_valid stays 1 with data B; drop_count=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; 10 strobes, then silence.
  - Required: RESTART exactly 16 cycles after the last strobe; timeout_count=1; busy 1→0.
  - Stimulus: no strobes at all for 100 cycles.
  - Required: no timeout.
- Saturation and priority:
  - Stimulus: 300 dropped frames.
  - Required: drop_count=255.
  - Stimulus: dec_full on the timeout cycle.
  - Required: capture taken; timeout_count unchanged.
